seg7_scan_driver: RTL

//  Parametrised multiplexed 7-segment driver: time-scans DIGITS hex digits onto shared segment lines.

---
 rtl/seg7_scan_driver.sv | 102 ++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment driver with double-buffered data,
// leading-zero blanking, PWM brightness, anti-ghost dead cycle and selectable pin polarity.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV_LOG2  = 17,
    parameter int BRIGHT_W       = 3,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [6:0]            segment,
    output logic                  dp,
    output logic                  frame_done
);
    localparam int   IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic SL = SEL_ACTIVE_LOW != 0;
    localparam logic GL = SEG_ACTIVE_LOW != 0;

    logic [SCAN_DIV_LOG2-1:0] cnt;
    logic [IW-1:0]            idx;
    logic [4*DIGITS-1:0]      pend_data, act_data;
    logic [DIGITS-1:0]        pend_dp, act_dp, blank, sel;
    logic                     slot_end, wrap, on, zrun;
    logic [3:0]               nib;
    logic [6:0]               seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        slot_end = &cnt;
        wrap     = slot_end && idx == IW'(DIGITS - 1);
        // cnt==0 is the dead cycle that lets the previous digit's segments settle
        on       = |cnt && (&brightness || cnt[SCAN_DIV_LOG2-1 -: BRIGHT_W] < brightness);
        nib      = act_data[{idx, 2'b00} +: 4];
        seg      = hex7(nib);
        zrun     = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun     = zrun && act_data[4*i +: 4] == 4'd0;
            blank[i] = blank_lz && i != 0 && zrun;
        end
        sel = on ? (DIGITS'(1) << idx) & ~blank : '0;
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            frame_done <= 1'b0;
            seg_sel    <= {DIGITS{SL}};
            segment    <= {7{GL}};
            dp         <= GL;
        end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= wrap;
            if (slot_end)
                idx <= wrap ? '0 : idx + 1'b1;
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            // a load on the boundary cycle bypasses pending so it shows this frame
            if (wrap) begin
                act_data <= load ? data_in : pend_data;
                act_dp   <= load ? dp_in : pend_dp;
            end
            seg_sel <= sel ^ {DIGITS{SL}};
            segment <= seg ^ {7{GL}};
            dp      <= (act_dp[idx] & ~blank[idx]) ^ GL;
        end
    end
endmodule
